rgb_seq_ctrl: RTL and testbench
===============================

Name: rgb_seq_ctrl

Overview:
Pattern sequencer and PWM controller for the board RGB LED.
- Steps through a fixed colour table, either hard-switching or fading between entries.
- Drives the three active-low LED pins through a shared per-channel PWM engine.
- Replaces the free-running blink logic as the block that sequences the LED datapath. Sits at top level between the system clock and the RGB0/RGB1/RGB2 pads.

Parameters:
- PWM_W, 8: PWM counter/duty width. Legal range 1..8.
- TICK_DIV, 4: clk cycles per PWM count increment. Must be ≥1.
- HOLD_PERIODS, 64: number of full PWM periods each step is held. Must be ≥1.
- FADE_STEP, 1: duty change per channel per PWM period during a fade, in PWM_W units.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 forces IDLE
- mode  in  1  0 = hard step, 1 = fade between steps
- RGB0  out  1  blue LED, active-low (0 = lit)
- RGB1  out  1  green LED, active-low
- RGB2  out  1  red LED, active-low
- step_idx  out  2  current table index
- step_pulse  out  1  one-cycle pulse when the index advances
- busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; step_idx=0; all duties and latched duties = 0.
  - Prescaler and PWM counter = 0.
  - RGB0/1/2 = 1 (off); step_pulse = 0; busy = 0.
- Time base:
  - The prescaler counts 0..TICK_DIV-1 and emits tick on its last count.
  - The PWM counter cnt (PWM_W bits) increments on tick and wraps from 2^PWM_W-1 to 0.
  - period_end = tick && cnt == max.
  - Both counters are held at 0 in IDLE.
  - Period length = TICK_DIV * 2^PWM_W clk cycles.
- PWM (per channel):
  - Latched duty is loaded from the duty register on period_end, so a new duty takes effect at the start of the next period.
  - Channel is lit while cnt < latched duty. Duty 0 means never lit; duty max means lit for 2^PWM_W-1 of 2^PWM_W counts.
  - Pin = ~lit, registered with one cycle of latency.
- Colour table (8-bit values, R,G,B):
  - entry 0 = FF,00,00
  - entry 1 = 00,FF,00
  - entry 2 = 00,00,FF
  - entry 3 = 40,40,40
  - Target duty = value >> (8-PWM_W).
- FSM states: IDLE, LOAD, HOLD, FADE.
  - IDLE: with en=1, go to LOAD on the next edge. Duties and latched duties = 0.
  - LOAD (1 cycle): target = table[step_idx].
    - mode=0: duty = target, go to HOLD.
    - mode=1: go to FADE.
    - mode is sampled only in LOAD.
  - FADE: on each period_end, each channel moves toward its target by FADE_STEP, saturating at the target (never overshoots, never wraps). When all three channels equal their targets after an update, go to HOLD.
  - HOLD: count period_end events. On the HOLD_PERIODS-th event:
    - step_idx = step_idx+1 mod 4 (3 wraps to 0);
    - step_pulse = 1 for that cycle;
    - go to LOAD.
  - The hold counter clears on entry to HOLD.
- en=0 in any state: go to IDLE on the next edge.
  - step_idx resets to 0; duties and latched duties clear immediately; pins go high the following cycle.
  - No step_pulse is emitted.
- Simultaneous events:
  - en=0 takes priority over period_end and step advance.
  - A mode change outside LOAD has no effect until the next LOAD.
- Reset asserted mid-sequence: immediate return to reset values, regardless of state.
- busy = (state != IDLE).

Decomposition:
- Package rgb_seq_pkg holds:
  - state enum (IDLE, LOAD, HOLD, FADE);
  - colour table constant (4 × 3 × 8 bits);
  - table depth and index width constants.
- One sub-module, rgb_pwm:
  - prescaler, PWM counter, per-channel duty latch and compare;
  - outputs period_end and the three active-low pins.
- rgb_seq_ctrl holds the FSM, hold counter, fade arithmetic and step index.

Test Plan:
All scenarios use PWM_W=4, TICK_DIV=1, HOLD_PERIODS=2, FADE_STEP=1 (16-cycle period).
1. Reset: rst=0 with en=1 held → RGB0/1/2=1, busy=0, step_idx=0. Release rst → busy=1 after one edge.
2. Hard step, mode=0, en=1:
   - Second period onward: RGB2 low for 15 of 16 cycles; RGB0 and RGB1 constantly high.
   - step_pulse fires after 2 period_ends; step_idx=1; then RGB1 is lit 15/16.
3. Wrap: run 4 steps in mode=0.
   - Entry 3 lights all pins 4/16 cycles each.
   - step_idx goes 3→0 with a pulse; red returns to 15/16.
4. Fade, mode=1, from entry 0 (red F) toward entry 1:
   - Red duty decrements F,E,…,0 and green increments 0→F, one unit per period.
   - HOLD is entered after 15 period_ends; step_pulse fires 2 periods later.
5. Abort: drop en mid-FADE → next cycle busy=0 and step_idx=0; all pins high on the following cycle; no step_pulse. Raise en → sequence restarts at entry 0.
6. Async reset mid-HOLD: assert rst between edges → outputs take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB LED pattern sequencer.
//   state_e    : sequencer FSM states
//   rgb8_t     : one 8-bit-per-channel colour table entry
//   COLOR_TBL  : fixed colour table, indexed by step index
package rgb_seq_pkg;

  localparam int unsigned TBL_DEPTH = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned COL_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    FADE = 2'd3
  } state_e;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb8_t;

  // Entry 0 at the least-significant end: red, green, blue, dim white.
  localparam rgb8_t [TBL_DEPTH-1:0] COLOR_TBL = {
    24'h404040,
    24'h0000ff,
    24'h00ff00,
    24'hff0000
  };

endpackage

// File: rtl/rgb_pwm.sv
// Shared-timebase PWM engine for three active-low LED channels.
//   clk, rst_n     : clock, async active-low reset
//   run_i          : time base advances while high
//   clr_i          : zero counters and latched duties this edge
//   duty_i         : per-channel duty, [2]=red [1]=green [0]=blue
//   period_end_c_o : last clock of a PWM period (combinational)
//   pins_o         : registered active-low pins, same channel order
module rgb_pwm #(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  clr_i,
  input  logic [2:0][PWM_W-1:0] duty_i,
  output logic                  period_end_c_o,
  output logic [2:0]            pins_o
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]        ps_q, ps_d;
  logic [PWM_W-1:0]       cnt_q, cnt_d;
  logic [2:0][PWM_W-1:0]  lat_q, lat_d;
  logic [2:0]             pins_d;
  logic                   tick_c;

  assign tick_c         = run_i && (ps_q == PS_W'(TICK_DIV - 1));
  assign period_end_c_o = tick_c && (cnt_q == CNT_MAX);

  // Time base, duty latch and compare.
  always_comb begin
    ps_d  = ps_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    if (clr_i) begin
      ps_d  = '0;
      cnt_d = '0;
      lat_d = '0;
    end else if (run_i) begin
      ps_d = tick_c ? '0 : PS_W'(ps_q + 1'b1);
      if (tick_c) cnt_d = PWM_W'(cnt_q + 1'b1);
      // New duty only takes effect at a period boundary.
      if (period_end_c_o) lat_d = duty_i;
    end
    for (int c = 0; c < 3; c++) begin
      pins_d[c] = ~(cnt_q < lat_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
      pins_o <= '1;
    end else begin
      ps_q   <= ps_d;
      cnt_q  <= cnt_d;
      lat_q  <= lat_d;
      pins_o <= pins_d;
    end
  end

endmodule

// File: rtl/rgb_seq_ctrl.sv
// RGB LED pattern sequencer: steps through the colour table, either
// hard-switching or fading, and drives the pads via rgb_pwm.
//   clk, rst         : clock, async active-low reset
//   en, mode         : run enable; 0 = hard step, 1 = fade
//   RGB0/RGB1/RGB2   : blue/green/red pads, active-low
//   step_idx         : current table index
//   step_pulse       : one-cycle pulse when the index advances
//   busy             : state is not IDLE
module rgb_seq_ctrl
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned TICK_DIV     = 4,
  parameter int unsigned HOLD_PERIODS = 64,
  parameter int unsigned FADE_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  output logic             RGB0,
  output logic             RGB1,
  output logic             RGB2,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_pulse,
  output logic             busy
);

  localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [2:0][PWM_W-1:0] duty_q, duty_d;
  logic [2:0][PWM_W-1:0] tgt_q, tgt_d;
  logic [2:0][PWM_W-1:0] tbl_tgt_c, faded_c;
  logic                  pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic                  period_end_c;
  logic [2:0]            pins;

  // One fade step toward the target, clamped so it never overshoots.
  function automatic logic [PWM_W-1:0] fade_ch(input logic [PWM_W-1:0] cur,
                                               input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] res;
    res = cur;
    if (cur < tgt) begin
      if (32'(tgt - cur) <= FADE_STEP) res = tgt;
      else                             res = PWM_W'(32'(cur) + FADE_STEP);
    end else if (cur > tgt) begin
      if (32'(cur - tgt) <= FADE_STEP) res = tgt;
      else                             res = PWM_W'(32'(cur) - FADE_STEP);
    end
    return res;
  endfunction

  // Table entry scaled down to the PWM resolution.
  always_comb begin
    tbl_tgt_c[2] = PWM_W'(COLOR_TBL[idx_q].r >> (COL_W - PWM_W));
    tbl_tgt_c[1] = PWM_W'(COLOR_TBL[idx_q].g >> (COL_W - PWM_W));
    tbl_tgt_c[0] = PWM_W'(COLOR_TBL[idx_q].b >> (COL_W - PWM_W));
    for (int c = 0; c < 3; c++) begin
      faded_c[c] = fade_ch(duty_q[c], tgt_q[c]);
    end
  end

  // Next-state and output logic; en=0 overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    pulse_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      hold_d  = '0;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d  = '0;
          state_d = LOAD;
        end
        LOAD: begin
          tgt_d = tbl_tgt_c;
          if (!mode) begin
            duty_d  = tbl_tgt_c;
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            state_d = FADE;
          end
        end
        FADE: begin
          if (period_end_c) begin
            duty_d = faded_c;
            if (faded_c == tgt_q) begin
              hold_d  = '0;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (period_end_c) begin
            if (hold_q == HOLD_W'(HOLD_PERIODS - 1)) begin
              idx_d   = IDX_W'(idx_q + 1'b1);
              pulse_d = 1'b1;
              state_d = LOAD;
            end else begin
              hold_d = HOLD_W'(hold_q + 1'b1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  logic pwm_run, pwm_clr;
  assign pwm_run = (state_q != IDLE);
  assign pwm_clr = (state_d == IDLE);

  rgb_pwm #(
    .PWM_W    (PWM_W),
    .TICK_DIV (TICK_DIV)
  ) u_pwm (
    .clk            (clk),
    .rst_n          (rst),
    .run_i          (pwm_run),
    .clr_i          (pwm_clr),
    .duty_i         (duty_q),
    .period_end_c_o (period_end_c),
    .pins_o         (pins)
  );

  assign RGB0       = pins[0];
  assign RGB1       = pins[1];
  assign RGB2       = pins[2];
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Self-checking bench for rgb_seq_ctrl with a 16-cycle PWM period.
module tb_rgb_seq_ctrl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic       mode = 1'b0;
  logic       RGB0, RGB1, RGB2;
  logic [1:0] step_idx;
  logic       step_pulse, busy;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  rgb_seq_ctrl #(
    .PWM_W        (4),
    .TICK_DIV     (1),
    .HOLD_PERIODS (2),
    .FADE_STEP    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .RGB0       (RGB0),
    .RGB1       (RGB1),
    .RGB2       (RGB2),
    .step_idx   (step_idx),
    .step_pulse (step_pulse),
    .busy       (busy)
  );

  typedef struct {
    logic       mode;
    int         r;
    int         g;
    int         b;
    logic [1:0] idx;
    int         pul;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next sampling point (falling edge), noting pulses.
  task automatic cyc_step();
    @(negedge clk);
    if (step_pulse === 1'b1) pulses++;
  endtask

  // Count lit cycles per pin over one 16-cycle window.
  task automatic measure(output int r, output int g, output int b,
                         output int p, output logic [1:0] idx0);
    int p0;
    p0 = pulses;
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 16; i++) begin
      cyc_step();
      if (i == 0) idx0 = step_idx;
      if (RGB2 === 1'b0) r++;
      if (RGB1 === 1'b0) g++;
      if (RGB0 === 1'b0) b++;
    end
    p = pulses - p0;
  endtask

  task automatic wait_pulse(input int budget);
    int p0;
    int n;
    p0 = pulses;
    n  = 0;
    while (pulses == p0 && n < budget) begin
      cyc_step();
      n++;
    end
    check("pulse_wait", 32'(pulses != p0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int r, g, b, p, exp_r, bad_pins, p0;
    logic [1:0] i0;

    // Hard-step schedule from reset release; mode=1 in HOLD must be ignored.
    vecs[0] = '{1'b0,  0,  0,  0, 2'd0, 0};
    vecs[1] = '{1'b1, 15,  0,  0, 2'd0, 1};
    vecs[2] = '{1'b0, 15,  0,  0, 2'd1, 0};
    vecs[3] = '{1'b0,  0, 15,  0, 2'd1, 1};
    vecs[4] = '{1'b0,  0, 15,  0, 2'd2, 0};
    vecs[5] = '{1'b0,  0,  0, 15, 2'd2, 1};
    vecs[6] = '{1'b0,  0,  0, 15, 2'd3, 0};
    vecs[7] = '{1'b0,  4,  4,  4, 2'd3, 1};
    vecs[8] = '{1'b0,  4,  4,  4, 2'd0, 0};
    vecs[9] = '{1'b0, 15,  0,  0, 2'd0, 1};

    // Reset held with en=1.
    #2 rst = 1'b0;
    en = 1'b1;
    repeat (3) cyc_step();
    check("rst_rgb0", RGB0, 1);
    check("rst_rgb1", RGB1, 1);
    check("rst_rgb2", RGB2, 1);
    check("rst_busy", busy, 0);
    check("rst_idx",  step_idx, 0);
    check("rst_pulse", step_pulse, 0);
    rst = 1'b1;
    cyc_step();
    check("rel_busy", busy, 1);
    check("rel_idx",  step_idx, 0);

    for (int k = 0; k < 10; k++) begin
      mode = vecs[k].mode;
      measure(r, g, b, p, i0);
      check($sformatf("hard%0d_r", k),   r,  vecs[k].r);
      check($sformatf("hard%0d_g", k),   g,  vecs[k].g);
      check($sformatf("hard%0d_b", k),   b,  vecs[k].b);
      check($sformatf("hard%0d_idx", k), i0, vecs[k].idx);
      check($sformatf("hard%0d_pul", k), p,  vecs[k].pul);
    end
    mode = 1'b0;

    // Fade from entry 0 (hard-loaded) toward entry 1.
    rst = 1'b0;
    cyc_step();
    check("rst2_busy", busy, 0);
    rst = 1'b1;
    cyc_step();
    cyc_step();
    mode = 1'b1;
    wait_pulse(100);
    check("fade_start_idx", step_idx, 1);
    repeat (16) cyc_step();
    for (int j = 1; j <= 16; j++) begin
      exp_r = (j <= 1) ? 15 : 16 - j;
      measure(r, g, b, p, i0);
      check($sformatf("fade%0d_r", j), r, exp_r);
      check($sformatf("fade%0d_g", j), g, 15 - exp_r);
      check($sformatf("fade%0d_b", j), b, 0);
      check($sformatf("fade%0d_pul", j), p, (j == 16) ? 1 : 0);
    end
    check("fade_end_idx", step_idx, 2);

    // Abort mid-fade.
    repeat (40) cyc_step();
    p0 = pulses;
    en = 1'b0;
    cyc_step();
    check("abort_busy", busy, 0);
    check("abort_idx",  step_idx, 0);
    cyc_step();
    check("abort_pins", {RGB2, RGB1, RGB0}, 3'b111);
    bad_pins = 0;
    repeat (30) begin
      cyc_step();
      if ({RGB2, RGB1, RGB0} !== 3'b111) bad_pins++;
    end
    check("idle_pins_dark", bad_pins, 0);
    check("abort_no_pulse", pulses - p0, 0);

    // Restart from entry 0 in hard mode.
    mode = 1'b0;
    en   = 1'b1;
    cyc_step();
    check("restart_busy", busy, 1);
    check("restart_idx",  step_idx, 0);
    measure(r, g, b, p, i0);
    check("restart_p0_r", r, 0);
    measure(r, g, b, p, i0);
    check("restart_p1_r", r, 15);
    check("restart_p1_g", g, 0);
    check("restart_p1_pul", p, 1);

    // Asynchronous reset in HOLD of entry 1 while green is lit.
    repeat (24) cyc_step();
    check("pre_rst_rgb1", RGB1, 0);
    check("pre_rst_idx",  step_idx, 1);
    rst = 1'b0;
    #1;
    check("async_rgb0", RGB0, 1);
    check("async_rgb1", RGB1, 1);
    check("async_rgb2", RGB2, 1);
    check("async_busy", busy, 0);
    check("async_idx",  step_idx, 0);
    check("async_pulse", step_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
